pipeline_hazard_ctrl: RTL
=========================

# pipeline_hazard_ctrl

Stall/flush controller for the 5-stage RISC-V pipeline. It complements the EX-stage forwarding unit and covers the cases forwarding cannot resolve:
- load-use dependencies;
- taken branches and jumps;
- multi-cycle mul/div occupancy of EX;
- data-memory wait states.

It drives the enable and clear inputs of the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It also keeps a memory-timeout error flag and saturating stall and flush performance counters.

## Interface
- MEM_TIMEOUT, 16: consecutive MEM_WAIT cycles after which MemErr sets.
- CNT_W, 32: width of the performance counters.
- clk  input  1  pipeline clock. One clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high.
- RS1D, RS2D  input  5  source registers of the instruction in ID.
- RDE  input  5  destination register of the instruction in EX.
- MemReadE  input  1  the instruction in EX is a load.
- PCSrcE  input  1  a branch or jump in EX is taken.
- MulDivE  input  1  the instruction in EX is a mul/div.
- MulDivDoneE  input  1  mul/div result valid this cycle.
- DMemReqM  input  1  the instruction in MEM accesses data memory.
- DMemReadyM  input  1  data memory completes the access this cycle.
- StallF, StallD, StallE, StallM  output  1  hold the PC and the IF/ID, ID/EX and EX/MEM registers.
- FlushD, FlushE, FlushM, FlushW  output  1  clear the IF/ID, ID/EX, EX/MEM and MEM/WB registers to a bubble.
- MemErr  output  1  sticky memory-timeout flag.
- StallCycles  output  CNT_W  count of cycles with StallF=1.
- FlushCount  output  CNT_W  count of taken-branch flushes.

## Operation
The FSM states are RUN, MD_BUSY and MEM_WAIT, plus a RetState register that holds RUN or MD_BUSY.

Hazard terms (combinational):
- memStall = DMemReqM & !DMemReadyM.
- mdStall = (state RUN & MulDivE) | (state MD_BUSY & !MulDivDoneE).
- loadUse = MemReadE & RDE!=0 & (RDE==RS1D | RDE==RS2D).

Output priority, first match wins. Every output not listed in the matching case is 0.
1. memStall: StallF, StallD, StallE and StallM = 1; FlushW = 1. PCSrcE is ignored; it is held in EX and acted on after release.
2. mdStall: StallF, StallD and StallE = 1; FlushM = 1.
3. PCSrcE: FlushD and FlushE = 1; no stall. A branch suppresses a simultaneous loadUse, because the dependent instruction is squashed.
4. loadUse: StallF and StallD = 1; FlushE = 1.

FSM transitions:
- RUN or MD_BUSY with memStall → MEM_WAIT. RetState is loaded with MD_BUSY if mdStall holds, otherwise RUN.
- RUN with MulDivE and no memStall → MD_BUSY.
- MD_BUSY with MulDivDoneE and no memStall → RUN. Stalls drop in the done cycle.
- MEM_WAIT with DMemReadyM → RetState. In MD_BUSY, MulDivDoneE is accepted during MEM_WAIT; RetState then becomes RUN.
- MulDivDoneE is never asserted in the cycle MulDivE first appears; minimum mul/div latency is 1 extra cycle.

Counters and flags:
- The memory-timeout counter increments each cycle in MEM_WAIT and clears on leaving it.
- When the timeout counter reaches MEM_TIMEOUT, MemErr sets and stays set until reset. The pipeline keeps waiting.
- StallCycles increments each cycle StallF=1. FlushCount increments each cycle that case 3 is the active case. Both saturate at 2^CNT_W−1.

## Timing
- Stall and flush outputs are combinational from the current inputs and state: zero-cycle latency within the cycle.
- State, RetState, the timeout counter, MemErr and the performance counters update on the rising edge.
- Synchronous reset gives: state RUN, RetState RUN, timeout counter 0, MemErr 0, StallCycles 0, FlushCount 0.
- While reset=1, all Stall and Flush outputs are forced to 0, regardless of the other inputs.
- Reset asserted mid-MD_BUSY or mid-MEM_WAIT returns to RUN on the next edge; no pending action survives.
- A load-use stall lasts exactly 1 cycle. The following cycle, EX holds a bubble, so loadUse is 0.

## Structure
- A shared package `hazard_pkg` holds:
  - the state enum `hz_state_t` {RUN, MD_BUSY, MEM_WAIT};
  - the constant `REG_ZERO` = 5'h00.
- One sub-module, `sat_counter`, parameterised by width, with increment enable and synchronous clear. It is instantiated twice, for StallCycles and FlushCount.

## Test plan
- Load-use: MemReadE=1, RDE=5, RS1D=5 → StallF=StallD=FlushE=1 for 1 cycle; StallCycles=1. Repeat with RDE=0 → no stall.
- Taken branch: PCSrcE=1 together with a loadUse condition → FlushD=FlushE=1, StallF=0; FlushCount increments by 1.
- Mul/div: MulDivE=1, MulDivDoneE asserted 4 cycles later → StallF/D/E=1 and FlushM=1 for 4 cycles; state RUN after the done edge.
- Memory wait inside mul/div:
  - Stimulus: while in MD_BUSY, DMemReadyM=0 for 3 cycles with DMemReqM=1.
  - Response: all four stalls and FlushW=1; return to MD_BUSY afterwards.
  - Repeat with MulDivDoneE pulsed during the wait → return to RUN.
- Timeout: MEM_TIMEOUT=4, DMemReadyM held 0 → MemErr=1 after 4 MEM_WAIT cycles and stays 1 after ready; it clears only on reset.
- Reset mid-MEM_WAIT: pulse reset=1 for 1 cycle → all outputs 0, state RUN, both counters 0.

Source files
------------

// File: rtl/hazard_pkg.sv
// rtl/hazard_pkg.sv - shared types and constants for the pipeline hazard controller
package hazard_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MD_BUSY  = 2'd1,
        MEM_WAIT = 2'd2
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'h00;

endpackage

// File: rtl/sat_counter.sv
// rtl/sat_counter.sv - saturating up-counter with synchronous clear
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    always_ff @(posedge clk) begin
        if (clr) begin
            count <= '0;
        end else if (inc && (count != '1)) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - stall/flush controller for the 5-stage pipeline
module pipeline_hazard_ctrl
    import hazard_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       RS1D,
    input  logic [4:0]       RS2D,
    input  logic [4:0]       RDE,
    input  logic             MemReadE,
    input  logic             PCSrcE,
    input  logic             MulDivE,
    input  logic             MulDivDoneE,
    input  logic             DMemReqM,
    input  logic             DMemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic             FlushW,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCycles,
    output logic [CNT_W-1:0] FlushCount
);

    localparam int TMO_W = $clog2(MEM_TIMEOUT + 1);
    localparam logic [TMO_W-1:0] TMO_MAX = TMO_W'(MEM_TIMEOUT);

    hz_state_t        state, state_next;
    hz_state_t        ret_state, ret_next;
    logic [TMO_W-1:0] tmo_cnt, tmo_next;
    logic             mem_stall, md_stall, load_use, branch_flush;

    assign mem_stall = DMemReqM & ~DMemReadyM;
    assign md_stall  = ((state == RUN) & MulDivE) | ((state == MD_BUSY) & ~MulDivDoneE);
    assign load_use  = MemReadE & (RDE != REG_ZERO) & ((RDE == RS1D) | (RDE == RS2D));

    always_comb begin
        StallF       = 1'b0;
        StallD       = 1'b0;
        StallE       = 1'b0;
        StallM       = 1'b0;
        FlushD       = 1'b0;
        FlushE       = 1'b0;
        FlushM       = 1'b0;
        FlushW       = 1'b0;
        branch_flush = 1'b0;
        state_next   = state;
        ret_next     = ret_state;
        tmo_next     = '0;

        // A pending branch waits behind memory and mul/div stalls; it is still in EX afterwards.
        if (!reset) begin
            if (mem_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                StallM = 1'b1;
                FlushW = 1'b1;
            end else if (md_stall) begin
                StallF = 1'b1;
                StallD = 1'b1;
                StallE = 1'b1;
                FlushM = 1'b1;
            end else if (PCSrcE) begin
                FlushD       = 1'b1;
                FlushE       = 1'b1;
                branch_flush = 1'b1;
            end else if (load_use) begin
                StallF = 1'b1;
                StallD = 1'b1;
                FlushE = 1'b1;
            end
        end

        case (state)
            RUN, MD_BUSY: begin
                if (mem_stall) begin
                    state_next = MEM_WAIT;
                    ret_next   = md_stall ? MD_BUSY : RUN;
                end else if (state == RUN && MulDivE) begin
                    state_next = MD_BUSY;
                end else if (state == MD_BUSY && MulDivDoneE) begin
                    state_next = RUN;
                end
            end
            MEM_WAIT: begin
                // A mul/div finishing while memory is stalled must not be lost.
                if (MulDivDoneE) begin
                    ret_next = RUN;
                end
                if (DMemReadyM) begin
                    state_next = MulDivDoneE ? RUN : ret_state;
                end else begin
                    tmo_next = (tmo_cnt == TMO_MAX) ? tmo_cnt : tmo_cnt + 1'b1;
                end
            end
            default: begin
                state_next = RUN;
                ret_next   = RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RUN;
            ret_state <= RUN;
            tmo_cnt   <= '0;
            MemErr    <= 1'b0;
        end else begin
            state     <= state_next;
            ret_state <= ret_next;
            tmo_cnt   <= tmo_next;
            if (tmo_next == TMO_MAX) begin
                MemErr <= 1'b1;
            end
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (StallF),
        .count (StallCycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr   (reset),
        .inc   (branch_flush),
        .count (FlushCount)
    );

endmodule
